mapper_mem_bridge: RTL

- Sits directly downstream of the cartridge mapper stage; consumes its mapper output (address, ram_cs, sram_cs, rnw) plus the CPU bus request strobe and write data.
- Turns each selected access into a single request/acknowledge transaction on the shared cartridge memory port, which is ROM in SDRAM with SRAM at a fixed offset.
- Stretches the CPU cycle via cpu_wait until the transaction completes, and returns read data to the CPU bus.

---
 rtl/mapper_mem_bridge_if.sv | 29 ++
 rtl/mapper_mem_bridge.sv | 117 +++++++++++
 2 files changed

// File: rtl/mapper_mem_bridge_if.sv
// Bus bundle between the cartridge mapper/CPU side and the shared cartridge memory port.
// The master modport is the bridge itself; the slave modport is the CPU/memory environment around it.
interface mapper_mem_bridge_if;
    logic        req;
    logic        ram_cs;
    logic        sram_cs;
    logic        rnw;
    logic [26:0] addr;
    logic [7:0]  wdata;
    logic        cpu_wait;
    logic [7:0]  rdata;
    logic        mem_req;
    logic [26:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        timeout_err;

    modport master (
        input  req, ram_cs, sram_cs, rnw, addr, wdata, mem_ack, mem_rdata,
        output cpu_wait, rdata, mem_req, mem_addr, mem_we, mem_wdata, timeout_err
    );

    modport slave (
        output req, ram_cs, sram_cs, rnw, addr, wdata, mem_ack, mem_rdata,
        input  cpu_wait, rdata, mem_req, mem_addr, mem_we, mem_wdata, timeout_err
    );
endinterface

// File: rtl/mapper_mem_bridge.sv
// Converts mapper-selected CPU accesses into req/ack transactions on the cartridge memory port.
// Define MAPPER_MEM_BRIDGE_RDCACHE_EN to add a single-entry read cache for ROM reads.
module mapper_mem_bridge #(
    parameter logic [26:0] SRAM_OFFSET = 27'h600_0000,
    parameter int          TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                reset,
    mapper_mem_bridge_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          start;
    logic [26:0]   next_addr;

    assign start = bus.req & (bus.ram_cs | bus.sram_cs) & (state == IDLE);

    // Combinational so the CPU is already stalled in the strobe cycle itself.
    assign bus.cpu_wait = start | (state != IDLE);

    // 27-bit add wraps modulo 2^27; sram_cs has priority over ram_cs.
    assign next_addr = bus.sram_cs ? bus.addr + SRAM_OFFSET : bus.addr;

`ifdef MAPPER_MEM_BRIDGE_RDCACHE_EN
    logic        c_valid;
    logic [26:0] c_tag;
    logic [7:0]  c_data;
    logic        hit;

    assign hit = bus.ram_cs & ~bus.sram_cs & c_valid & (c_tag == bus.addr);
`endif

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.rdata       <= 8'hFF;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_we      <= 1'b0;
            bus.mem_wdata   <= '0;
            bus.timeout_err <= 1'b0;
`ifdef MAPPER_MEM_BRIDGE_RDCACHE_EN
            // NOTE: only the valid bit needs reset; tag and data are ignored while invalid.
            c_valid         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bus.mem_addr  <= next_addr;
                        bus.mem_we    <= bus.sram_cs & ~bus.rnw;
                        bus.mem_wdata <= bus.wdata;
                        cnt           <= '0;
`ifdef MAPPER_MEM_BRIDGE_RDCACHE_EN
                        if (hit) begin
                            bus.rdata <= c_data;
                            state     <= DONE;
                        end else begin
                            bus.mem_req <= 1'b1;
                            state       <= BUSY;
                        end
`else
                        bus.mem_req <= 1'b1;
                        state       <= BUSY;
`endif
                    end
                end

                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= DONE;
                        if (!bus.mem_we) begin
                            bus.rdata <= bus.mem_rdata;
                        end
`ifdef MAPPER_MEM_BRIDGE_RDCACHE_EN
                        if (!bus.mem_we) begin
                            c_valid <= 1'b1;
                            c_tag   <= bus.mem_addr;
                            c_data  <= bus.mem_rdata;
                        end else if (c_valid && (c_tag == bus.mem_addr)) begin
                            c_data  <= bus.mem_wdata;
                        end
`endif
                    end else if (cnt == CNT_LAST) begin
                        bus.mem_req     <= 1'b0;
                        bus.rdata       <= 8'hFF;
                        bus.timeout_err <= 1'b1;
                        state           <= DONE;
`ifdef MAPPER_MEM_BRIDGE_RDCACHE_EN
                        c_valid         <= 1'b0;
`endif
                    end
                end

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule
